resource_arbiter_8: RTL
=======================

// Module: resource_arbiter_8
// PURPOSE
// - Shares one resource among 8 requesters; one owner at a time.
// - Ownership is held from grant until the owner drops its request.
// - Selectable round-robin or fixed-priority. Fixed priority: highest index wins, same rule as the 8-to-3 priority encoder.
// - Sits between requester agents and the shared resource; grant_id drives the resource's select mux.
// PARAMETERS
// - N_REQ     8    number of requesters; fixed at 8 in this revision
// - ID_W      3    grant_id width, $clog2(N_REQ)
// - MAX_HOLD  16   cycles an owner may hold the grant; used only with ARB_TIMEOUT_EN
// PORTS
// - clk          in   1      single clock, rising edge
// - rst          in   1      synchronous reset, active-high
// - enable       in   1      1 = new grants allowed
// - mode         in   1      0 = round-robin, 1 = fixed priority (highest index)
// - req          in   8      request vector; owner holds its bit high while using the resource
// - grant        out  8      one-hot grant, registered
// - grant_id     out  3      binary index of the owner, registered
// - grant_valid  out  1      1 = grant/grant_id are meaningful
// - timeout      out  1      1-cycle pulse on forced release; tied 0 without ARB_TIMEOUT_EN
// BEHAVIOUR
// - All outputs are registered. Reset applies at the clk edge while rst=1.
// - Reset values: grant=0, grant_id=0, grant_valid=0, timeout=0, rr_ptr=0, state=IDLE.
// - FSM states: IDLE, BUSY.
// - IDLE, enable=1 and |req: the pick is registered, so grant appears 1 cycle after req is sampled. Next state BUSY.
// - IDLE, otherwise: outputs stay 0 and state stays IDLE.
// - Pick, mode=0: first set bit searching upward from rr_ptr, wrapping 7->0.
// - Pick, mode=1: highest set index; rr_ptr is ignored.
// - Every grant to index k sets rr_ptr=(k+1)%8 in both modes.
// - BUSY, req[grant_id]=1: grant, grant_id and grant_valid are held. No preemption.
// - BUSY, req[grant_id]=0 (release): the release cycle is evaluated exactly as IDLE, excluding the old owner.
//   - If enable=1 and another bit is set, the new grant is registered at that edge. No dead cycle between owners.
//   - Otherwise grant=0, grant_valid=0 and the next state is IDLE. grant_id keeps its last value.
// - enable=0 during BUSY: the current owner keeps the grant. No new grant is issued after its release.
// - A req bit that rises and falls while not owner is ignored. No request latching.
// - grant is always one-hot or zero; grant_valid==|grant.
// - rst mid-ownership: grant revoked at that edge, rr_ptr=0.
// CONFIGURATION
// - Macro ARB_TIMEOUT_EN.
// - Defined:
//   - A hold counter of $clog2(MAX_HOLD+1) bits clears on each new grant and counts BUSY cycles.
//   - When the owner has held MAX_HOLD cycles, the grant is revoked at the next edge and timeout pulses 1 cycle.
//   - Revocation is evaluated as a release.
//   - The revoked index is masked from picks until its req bit is seen low.
//   - The mask clears on rst.
// - Not defined: no counter or mask; ownership is unbounded; timeout is constant 0.
// STRUCTURE
// - Package arb_pkg:
//   - typedef enum logic {IDLE, BUSY} arb_state_t
//   - localparam N_REQ=8, ID_W=3
//   - function onehot(id)
// - Sub-module arb_pick_encoder (combinational):
//   - inputs: req_masked, rr_ptr, mode
//   - outputs: pick_id, pick_valid
//   - rotate -> priority encode -> un-rotate for mode=0; plain highest-index encode for mode=1.
// - Top holds the FSM, rr_ptr, output registers and the optional timeout logic.
// TESTING
// - Reset:
//   - rst=1 for 2 cycles with req=8'hFF, enable=1 -> grant=0, grant_id=0, grant_valid=0.
// - Round-robin:
//   - mode=0, req=8'b1000_0001 from reset -> grant_id=0 at the next edge.
//   - Drop req[0] -> grant_id=7 at the following edge.
//   - Drop req[7], raise req[0] -> grant_id=0 with no dead cycle.
// - Fixed priority:
//   - mode=1, req=8'b1010_0000 -> grant_id=7, grant=8'h80.
//   - Drop req[7] -> grant_id=5, grant=8'h20.
// - Enable gating:
//   - enable=0, req=8'h08 for 5 cycles -> grant_valid=0.
//   - Set enable=1 -> grant_id=3 at the next edge.
//   - Clear enable=0 while req[3] is held -> grant stays 8'h08.
//   - Drop req[3] -> grant_valid=0 at the next edge.
// - Idle / random:
//   - req=0 -> grant_valid stays 0.
//   - 200 cycles of random req/mode/enable -> grant one-hot or zero, grant_valid==|grant.
//   - Every grant bit is set only where req was set on the preceding sampled edge.
// - Timeout (ARB_TIMEOUT_EN, MAX_HOLD=4):
//   - req[2] held high, req[4] held high, mode=0 -> grant_id=2 for 4 cycles.
//   - Then timeout=1 for 1 cycle and grant_id=4 at the same edge.
//   - req[2] is not regranted until it goes low and returns high.

Source files
------------

// File: rtl/arb_pkg.sv
// ---------------------------------------------------------------------------
// arb_pkg
// Shared types and constants for the 8-way resource arbiter.
//   arb_state_t : FSM state (IDLE = no owner, BUSY = an owner holds the grant)
//   N_REQ, ID_W : requester count and grant index width
//   onehot()    : binary index -> one-hot request/grant vector
// ---------------------------------------------------------------------------
package arb_pkg;

    localparam int N_REQ = 8;
    localparam int ID_W  = 3;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    function automatic logic [N_REQ-1:0] onehot(input logic [ID_W-1:0] id);
        logic [N_REQ-1:0] v;
        v = '0;
        v[id] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/arb_pick_encoder.sv
// ---------------------------------------------------------------------------
// arb_pick_encoder
// Combinational winner selection among eligible requesters.
//   req_masked : eligible request bits (owner / timed-out bits already removed)
//   rr_ptr     : round-robin search start index
//   mode       : 0 = round-robin from rr_ptr (wrapping 7->0), 1 = highest index
//   pick_id    : selected index (meaningful only when pick_valid=1)
//   pick_valid : at least one eligible request
// ---------------------------------------------------------------------------
module arb_pick_encoder
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req_masked,
    input  logic [ID_W-1:0]  rr_ptr,
    input  logic             mode,
    output logic [ID_W-1:0]  pick_id,
    output logic             pick_valid
);

    // Rotate so that bit rr_ptr lands at position 0; the lowest set bit of
    // the rotated vector is then the first requester at or after rr_ptr.
    logic [N_REQ-1:0] rotated;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
            logic [ID_W-1:0] src;
            assign src         = rr_ptr + ID_W'(gi);
            assign rotated[gi] = req_masked[src];
        end
    endgenerate

    logic [ID_W-1:0] rot_first;
    logic [ID_W-1:0] high_id;

    always_comb begin
        rot_first = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                rot_first = ID_W'(i);
            end
        end
    end

    always_comb begin
        high_id = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (req_masked[i]) begin
                high_id = ID_W'(i);
            end
        end
    end

    // Un-rotate: adding rr_ptr back wraps naturally in ID_W bits.
    assign pick_id    = mode ? high_id : (rot_first + rr_ptr);
    assign pick_valid = |req_masked;

endmodule

// File: rtl/resource_arbiter_8.sv
// ---------------------------------------------------------------------------
// resource_arbiter_8
// Shares one resource among 8 requesters. An owner keeps the grant until it
// drops its request; the release cycle immediately re-arbitrates among the
// others so there is no dead cycle between owners.
//
// Ports:
//   clk, rst     : clock (rising edge) and synchronous active-high reset
//   enable       : 1 = new grants may be issued
//   mode         : 0 = round-robin, 1 = fixed priority (highest index)
//   req[7:0]     : request vector, held high by the owner while in use
//   grant[7:0]   : registered one-hot grant
//   grant_id     : registered binary owner index (kept after release)
//   grant_valid  : registered, equals |grant
//   timeout      : 1-cycle pulse on forced release
//
// Optional feature (macro ARB_TIMEOUT_EN): owners are limited to MAX_HOLD
// cycles; an expired owner is revoked, pulses timeout and stays masked from
// picks until its request is seen low. Without the macro, ownership is
// unbounded and timeout is constant 0.
// ---------------------------------------------------------------------------
module resource_arbiter_8
    import arb_pkg::*;
`ifdef ARB_TIMEOUT_EN
#(
    parameter int MAX_HOLD = 16
)
`endif
(
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              mode,
    input  logic [N_REQ-1:0]  req,
    output logic [N_REQ-1:0]  grant,
    output logic [ID_W-1:0]   grant_id,
    output logic              grant_valid,
    output logic              timeout
);

    arb_state_t       state_reg,       state_next;
    logic [N_REQ-1:0] grant_reg,       grant_next;
    logic [ID_W-1:0]  grant_id_reg,    grant_id_next;
    logic             grant_valid_reg, grant_valid_next;
    logic [ID_W-1:0]  rr_ptr_reg,      rr_ptr_next;

    logic             expire;       // current owner has used up its hold budget
    logic             hold_owner;   // owner keeps the grant this cycle
    logic             new_grant;    // a fresh grant is registered this edge
    logic [N_REQ-1:0] exclude;      // bits not eligible for this pick
    logic [N_REQ-1:0] req_masked;
    logic [ID_W-1:0]  pick_id;
    logic             pick_valid;

    // The outgoing owner must not win its own release cycle (matters for
    // forced release, where its req bit may still be high). In IDLE the
    // stale grant_id is not an owner and excludes nothing.
    assign exclude = (state_reg == BUSY) ? onehot(grant_id_reg) : '0;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(MAX_HOLD + 1);

    logic [CNT_W-1:0] hold_cnt_reg, hold_cnt_next;
    logic [N_REQ-1:0] mask_reg,     mask_next;
    logic             timeout_reg;

    // hold_cnt is 0 in the first owned cycle, so MAX_HOLD-1 marks the last one.
    assign expire     = (state_reg == BUSY) && (hold_cnt_reg == CNT_W'(MAX_HOLD - 1));
    assign req_masked = req & ~exclude & ~mask_reg;

    // A masked bit is released once its request is seen low; the revoked
    // owner is added in the revocation cycle.
    always_comb begin
        mask_next = mask_reg & req;
        if (expire) begin
            mask_next = mask_next | onehot(grant_id_reg);
        end
    end

    always_comb begin
        hold_cnt_next = hold_cnt_reg;
        if (new_grant) begin
            hold_cnt_next = '0;
        end else if (hold_owner) begin
            hold_cnt_next = hold_cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt_reg <= '0;
            mask_reg     <= '0;
            timeout_reg  <= 1'b0;
        end else begin
            hold_cnt_reg <= hold_cnt_next;
            mask_reg     <= mask_next;
            timeout_reg  <= expire;
        end
    end

    assign timeout = timeout_reg;
`else
    assign expire     = 1'b0;
    assign req_masked = req & ~exclude;
    assign timeout    = 1'b0;
`endif

    arb_pick_encoder u_pick (
        .req_masked (req_masked),
        .rr_ptr     (rr_ptr_reg),
        .mode       (mode),
        .pick_id    (pick_id),
        .pick_valid (pick_valid)
    );

    assign hold_owner = (state_reg == BUSY) && req[grant_id_reg] && !expire;

    // IDLE and a BUSY release cycle share the same arbitration path.
    always_comb begin
        state_next       = state_reg;
        grant_next       = grant_reg;
        grant_id_next    = grant_id_reg;
        grant_valid_next = grant_valid_reg;
        rr_ptr_next      = rr_ptr_reg;
        new_grant        = 1'b0;

        if (!hold_owner) begin
            if (enable && pick_valid) begin
                state_next       = BUSY;
                grant_next       = onehot(pick_id);
                grant_id_next    = pick_id;
                grant_valid_next = 1'b1;
                rr_ptr_next      = pick_id + ID_W'(1);
                new_grant        = 1'b1;
            end else begin
                state_next       = IDLE;
                grant_next       = '0;
                grant_valid_next = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            grant_reg       <= '0;
            grant_id_reg    <= '0;
            grant_valid_reg <= 1'b0;
            rr_ptr_reg      <= '0;
        end else begin
            state_reg       <= state_next;
            grant_reg       <= grant_next;
            grant_id_reg    <= grant_id_next;
            grant_valid_reg <= grant_valid_next;
            rr_ptr_reg      <= rr_ptr_next;
        end
    end

    assign grant       = grant_reg;
    assign grant_id    = grant_id_reg;
    assign grant_valid = grant_valid_reg;

endmodule
